// File: rtl/puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package puf_pkg;

    localparam int SEL_W  = 5;
    localparam int CHAL_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel_b;
        logic [SEL_W-1:0] sel_a;
    } sel_pair_t;

    // Oscillator pair k: both bases advance by k with 5-bit wrap. A ring
    // compared against itself carries no entropy, so a collision moves B
    // on by one.
    function automatic sel_pair_t pair_sel(input logic [CHAL_W-1:0] chal,
                                           input logic [SEL_W-1:0]  k);
        sel_pair_t p;
        p.sel_a = chal[SEL_W-1:0] + k;
        p.sel_b = chal[CHAL_W-1:SEL_W] + k;
        if (p.sel_a == p.sel_b) begin
            p.sel_b = p.sel_b + 1'b1;
        end
        return p;
    endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Synchronises one asynchronous oscillator output and counts its rising edges, saturating at all-ones.
// Latency: an edge on ro reaches the counter 3 clk cycles later (2 sync flops + 1 edge-detect flop).
// Backpressure: none; clr has priority over en, and counting stops while en is low.
module puf_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise;

    // Synchroniser shift, edge detection and saturating count.
    always_comb begin
        sync1_d = ro;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/puf_measure_ctrl.sv
// Sequences RESP_BITS ring-oscillator pair measurements from a challenge and builds the response word.
// Latency: done pulses 1 + RESP_BITS*(SETTLE_CYC+WIN_CYC+1) cycles after the start-accept cycle (inclusive).
// Backpressure: none; start is only accepted in IDLE and is silently dropped while busy or in the done cycle.
module puf_measure_ctrl
    import puf_pkg::*;
#(
    parameter int RESP_BITS  = 8,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    challenge,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 ro_en,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 tie_seen
);

    localparam int K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d;
    logic [SEL_W-1:0]     sel_b_q, sel_b_d;
    logic                 ro_en_q, ro_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 tie_q, tie_d;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;
    logic                 resp_bit;
    sel_pair_t            first_pair;
    sel_pair_t            next_pair;

    puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .ro  (ro_a),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_a)
    );

    puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .ro  (ro_b),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt_b)
    );

    // Next-state, timer, pair-index, select and response update logic.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tmr_d      = tmr_q;
        chal_d     = chal_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        ro_en_d    = ro_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        response_d = response_q;
        tie_d      = tie_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        resp_bit   = (cnt_a > cnt_b);
        first_pair = pair_sel(challenge, '0);
        next_pair  = pair_sel(chal_q, SEL_W'(k_q) + SEL_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d     = challenge;
                    k_d        = '0;
                    tmr_d      = '0;
                    response_d = '0;
                    tie_d      = 1'b0;
                    busy_d     = 1'b1;
                    ro_en_d    = 1'b1;
                    sel_a_d    = first_pair.sel_a;
                    sel_b_d    = first_pair.sel_b;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Counters stay cleared while the muxes and synchronisers settle.
                cnt_clr = 1'b1;
                if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_MEASURE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                cnt_en = 1'b1;
                if (tmr_q == TMR_W'(WIN_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_COMPARE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                for (int i = 0; i < RESP_BITS; i++) begin
                    if (k_q == K_W'(i)) begin
                        response_d[i] = resp_bit;
                    end
                end
                tie_d = tie_q | (cnt_a == cnt_b);
                if (k_q == K_W'(RESP_BITS - 1)) begin
                    busy_d  = 1'b0;
                    ro_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    sel_a_d = next_pair.sel_a;
                    sel_b_d = next_pair.sel_b;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            tmr_q      <= '0;
            chal_q     <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            ro_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            response_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            tmr_q      <= tmr_d;
            chal_q     <= chal_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            ro_en_q    <= ro_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            response_q <= response_d;
            tie_q      <= tie_d;
        end
    end

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign ro_en    = ro_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = response_q;
    assign tie_seen = tie_q;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Directed bench for puf_measure_ctrl with behavioural ring oscillators.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_puf_measure_ctrl;

    logic       clk = 1'b0;
    logic       rst1, rst2, start1, start2;
    logic [9:0] chal;
    logic       ro_a, ro_b, ro_b_in, tie_mode;
    int         half_a = 20;
    int         half_b = 30;

    logic [4:0] sel_a1, sel_b1, sel_a2, sel_b2;
    logic       ro_en1, busy1, done1, tie1;
    logic       ro_en2, busy2, done2, tie2;
    logic [3:0] resp1, resp2;

    int checks = 0;
    int errors = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;

    always #5 clk = ~clk;

    // Oscillators start off the clock grid (t=3) with half-periods that are
    // multiples of 5, so a ring transition never lands on a rising clk edge.
    initial begin
        ro_a = 1'b0;
        #3;
        forever begin
            #(half_a) ro_a = ~ro_a;
        end
    end

    initial begin
        ro_b = 1'b0;
        #3;
        forever begin
            #(half_b) ro_b = ~ro_b;
        end
    end

    assign ro_b_in = tie_mode ? ro_a : ro_b;

    always @(posedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
    end

    puf_measure_ctrl #(.RESP_BITS(4), .WIN_CYC(64), .SETTLE_CYC(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .challenge(chal),
        .ro_a(ro_a), .ro_b(ro_b_in),
        .sel_a(sel_a1), .sel_b(sel_b1), .ro_en(ro_en1), .busy(busy1),
        .done(done1), .response(resp1), .tie_seen(tie1)
    );

    puf_measure_ctrl #(.RESP_BITS(4), .WIN_CYC(64), .SETTLE_CYC(4), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .challenge(chal),
        .ro_a(ro_a), .ro_b(ro_b_in),
        .sel_a(sel_a2), .sel_b(sel_b2), .ro_en(ro_en2), .busy(busy2),
        .done(done2), .response(resp2), .tie_seen(tie2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle; returns at the negedge after the accept edge.
    task automatic do_start(input bit which, input logic [9:0] ch);
        @(negedge clk);
        chal = ch;
        if (which) start2 = 1'b1;
        else       start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Counts rising edges until done is seen, bounded so a dead DUT still ends.
    task automatic wait_done(input bit which, input int start_edges, output int edges);
        edges = start_edges;
        while (!(which ? done2 : done1) && edges < 5000) begin
            @(negedge clk);
            edges++;
        end
    endtask

    logic [4:0] exp_sa [4];
    logic [4:0] exp_sb [4];

    initial begin
        int e;
        int dc;
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        chal = 10'h000; tie_mode = 1'b0;
        exp_sa[0] = 5'd31; exp_sa[1] = 5'd0; exp_sa[2] = 5'd1; exp_sa[3] = 5'd2;
        exp_sb[0] = 5'd0;  exp_sb[1] = 5'd1; exp_sb[2] = 5'd2; exp_sb[3] = 5'd3;
        repeat (3) @(negedge clk);

        // Reset state on both instances.
        check("rst_sel1",  32'({sel_a1, sel_b1}), 32'h0);
        check("rst_flags1", 32'({ro_en1, busy1, done1, tie1}), 32'h0);
        check("rst_resp1", 32'(resp1), 32'h0);
        check("rst_sel2",  32'({sel_a2, sel_b2}), 32'h0);
        check("rst_flags2", 32'({ro_en2, busy2, done2, tie2}), 32'h0);
        check("rst_resp2", 32'(resp2), 32'h0);
        rst1 = 1'b0; rst2 = 1'b0;

        // 1: A period 4 clk, B period 6 clk, challenge 0.
        half_a = 20; half_b = 30;
        repeat (5) @(negedge clk);
        do_start(1'b0, 10'h000);
        check("t1_busy_ren", 32'({busy1, ro_en1}), 32'h3);
        check("t1_sel0", 32'({sel_a1, sel_b1}), 32'({5'd0, 5'd1}));
        wait_done(1'b0, 1, e);
        check("t1_latency", 32'(e), 32'd277);
        check("t1_resp", 32'(resp1), 32'hF);
        check("t1_tie", 32'(tie1), 32'h0);
        check("t1_done_flags", 32'({busy1, ro_en1}), 32'h0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done1), 32'h0);
        check("t1_resp_hold", 32'(resp1), 32'hF);

        // 2: A and B identical, period 8 clk.
        tie_mode = 1'b1; half_a = 40;
        repeat (10) @(negedge clk);
        do_start(1'b0, 10'h000);
        check("t2_clear", 32'({resp1, tie1}), 32'h0);
        wait_done(1'b0, 1, e);
        check("t2_resp", 32'(resp1), 32'h0);
        check("t2_tie", 32'(tie1), 32'h1);

        // 3: wrap and collision bump on the selects.
        tie_mode = 1'b0; half_a = 20; half_b = 30;
        repeat (10) @(negedge clk);
        do_start(1'b0, {5'd31, 5'd31});
        check("t3_tie_clear", 32'(tie1), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_sel_a%0d", k), 32'(sel_a1), 32'(exp_sa[k]));
            check($sformatf("t3_sel_b%0d", k), 32'(sel_b1), 32'(exp_sb[k]));
            if (k < 3) repeat (69) @(negedge clk);
        end
        wait_done(1'b0, 208, e);
        check("t3_latency", 32'(e), 32'd277);

        // 4: 4-bit counters, both rings fast enough to saturate.
        half_a = 10; half_b = 15;
        repeat (10) @(negedge clk);
        do_start(1'b1, 10'h000);
        wait_done(1'b1, 1, e);
        check("t4_latency", 32'(e), 32'd277);
        check("t4_resp", 32'(resp2), 32'h0);
        check("t4_tie", 32'(tie2), 32'h1);

        // 5: reset during MEASURE of pair 2.
        half_a = 20; half_b = 30;
        repeat (10) @(negedge clk);
        do_start(1'b0, 10'h000);
        repeat (149) @(negedge clk);
        check("t5_pre_resp", 32'(resp1), 32'h3);
        check("t5_pre_busy", 32'(busy1), 32'h1);
        dc = done_cnt1;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("t5_rst_sel", 32'({sel_a1, sel_b1}), 32'h0);
        check("t5_rst_flags", 32'({ro_en1, busy1, done1, tie1}), 32'h0);
        check("t5_rst_resp", 32'(resp1), 32'h0);
        repeat (300) @(negedge clk);
        check("t5_no_done", 32'(done_cnt1), 32'(dc));
        check("t5_idle", 32'(busy1), 32'h0);
        do_start(1'b0, 10'h000);
        wait_done(1'b0, 1, e);
        check("t5_rerun_latency", 32'(e), 32'd277);
        check("t5_rerun_resp", 32'(resp1), 32'hF);

        // 6: start while busy and in the DONE cycle is ignored.
        repeat (5) @(negedge clk);
        dc = done_cnt1;
        do_start(1'b0, 10'h000);
        repeat (20) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0, 22, e);
        check("t6_latency", 32'(e), 32'd277);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t6_after_done", 32'({busy1, done1, ro_en1}), 32'h0);
        repeat (20) @(negedge clk);
        check("t6_still_idle", 32'(busy1), 32'h0);
        check("t6_one_done", 32'(done_cnt1), 32'(dc + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
